mio_bus_ctrl: RTL and testbench
===============================

Name: mio_bus_ctrl

Overview:
- Memory-side bus controller between the multi-cycle CPU's memory port (Addr_out, Data_out, mem_w, Data_in, MIO_ready) and the word-organised Memory block.
- Replaces the fixed all-lanes byte enable and fixed unsigned read path.
- Converts each CPU byte, halfword or word access into a word-aligned memory transaction with byte enables and lane steering.
- Sequences the memory latency and returns a one-cycle ready pulse (MIO_ready) with sign- or zero-extended load data.

Parameters:
WAIT_CYCLES, 2, memory access latency in cycles; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
cpu_req  input  1  CPU access request; sampled only in IDLE.
cpu_we  input  1  1 = store, 0 = load.
cpu_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
cpu_sign  input  1  load extension: 1 = sign-extend, 0 = zero-extend.
cpu_addr  input  32  byte address.
cpu_wdata  input  32  store data, right-justified.
cpu_rdata  output  32  extended load data; feeds CPU Data_in.
cpu_ready  output  1  one-cycle completion pulse; feeds CPU MIO_ready.
cpu_err  output  1  misaligned or illegal-size flag; valid with cpu_ready.
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
mem_wdata  output  32  lane-replicated store data.
mem_we  output  1  memory write strobe.
mem_be  output  4  byte-lane enables.
mem_rdata  input  32  memory read word.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; counter = 0.
  - All outputs go to 0, including the cpu_rdata holding register.
  - Reset mid-access aborts the access with no ready pulse; mem_we drops immediately.
- Byte ordering is little-endian: lane k = data[8k+7:8k] for addr[1:0] = k.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On cpu_req=1, latch addr, we, size, sign and wdata.
  - Alignment check: halfword needs addr[0]=0; word needs addr[1:0]=00; size 11 is always illegal.
  - Bad access: go to RESP with the error latched. No memory transaction: mem_be and mem_we stay 0.
  - Good access: go to ACCESS with counter = 0.
- ACCESS:
  - mem_addr, mem_be and mem_wdata come from the latched values and are held stable for the whole state.
  - Byte: be = 0001 << addr[1:0]; wdata = {4{b}}.
  - Halfword: be = 0011 << addr[1:0]; wdata = {2{h}}.
  - Word: be = 1111.
  - Counter increments each cycle.
  - When counter == WAIT_CYCLES-1:
    - Store: mem_we=1 for exactly this one cycle.
    - Load: sample mem_rdata, pick the addressed lane(s), extend to 32 bits per the latched sign, and register the result into cpu_rdata.
    - Go to RESP.
- RESP:
  - cpu_ready=1 for exactly one cycle; cpu_err = latched error; then go to IDLE.
  - cpu_rdata holds its value until the next load completes. Stores and errors leave it unchanged.
- cpu_req is ignored outside IDLE. A request still held high during RESP is taken as a new access only on the IDLE cycle that follows.
- Latency from request cycle to ready: WAIT_CYCLES+1 cycles for a valid access, 1 cycle for an errored one. Minimum spacing between accesses is WAIT_CYCLES+2 cycles.
- mem_be=0 and mem_we=0 whenever the FSM is not in ACCESS. mem_addr and mem_wdata hold their last value.
- cpu_err is 0 except during a RESP cycle for an errored access.

Test Plan:
1. Reset: hold rst=0 during a request, release -> all outputs 0, state IDLE. Assert rst=0 mid-ACCESS -> mem_we and mem_be go to 0 at once, no cpu_ready.
2. Word store then load, WAIT_CYCLES=2: store 0x11223344 at 0x100 -> mem_be=1111 and mem_we high one cycle, cpu_ready 3 cycles after request. Load 0x100 -> cpu_rdata=0x11223344.
3. Byte stores and loads: store 0xA5 at 0x103 -> mem_be=1000, mem_wdata=0xA5A5A5A5. Signed byte load of 0x103 -> 0xFFFFFFA5. Unsigned byte load of 0x103 -> 0x000000A5.
4. Halfword: store 0x8001 at 0x102 -> mem_be=1100. Signed halfword load -> 0xFFFF8001. Unsigned halfword load -> 0x00008001.
5. Errors:
   - Halfword load at 0x101 -> cpu_ready and cpu_err on the next cycle, mem_be never nonzero.
   - Word store at 0x102 -> same response, no memory write.
   - cpu_size=11 -> cpu_err=1.
6. Back-to-back and latency sweep: cpu_req held high continuously -> one ready pulse per WAIT_CYCLES+2 cycles, no access dropped or duplicated. Repeat with WAIT_CYCLES=1 and WAIT_CYCLES=4.

Source files
------------

// File: rtl/mio_bus_ctrl_if.sv
// mio_bus_ctrl_if: CPU-side and memory-side signals of the bus controller.
// slave is the controller's view, master the environment's.
interface mio_bus_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_sign;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_sign,
    input  cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_ready, cpu_err,
    output mem_addr, mem_wdata, mem_we, mem_be
  );

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_sign,
    output cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_ready, cpu_err,
    input  mem_addr, mem_wdata, mem_we, mem_be
  );
endinterface

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: byte/half/word CPU accesses onto a word memory with
// byte enables, lane steering, fixed latency and load extension.
module mio_bus_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  mio_bus_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_sign;
  logic        r_err;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [3:0]  r_be;
  logic [31:0] r_maddr;
  logic [31:0] r_mwdata;
  logic [31:0] r_rdata;

  logic        w_bad;
  logic        w_last;
  logic        w_take;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_sh;
  logic [31:0] w_ext;

  assign w_take = (r_state == S_IDLE) && bus.cpu_req;
  assign w_last = (r_state == S_ACCESS) && (r_cnt == LAST);

  always_comb begin
    w_bad = 1'b0;
    unique case (1'b1)
      (bus.cpu_size == 2'b00): w_bad = 1'b0;
      (bus.cpu_size == 2'b01): w_bad = bus.cpu_addr[0];
      (bus.cpu_size == 2'b10): w_bad = |bus.cpu_addr[1:0];
      default:                 w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.cpu_wdata;
    unique case (1'b1)
      (bus.cpu_size == 2'b00): begin
        w_be    = 4'b0001 << bus.cpu_addr[1:0];
        w_wdata = {4{bus.cpu_wdata[7:0]}};
      end
      (bus.cpu_size == 2'b01): begin
        w_be    = 4'b0011 << bus.cpu_addr[1:0];
        w_wdata = {2{bus.cpu_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = bus.cpu_wdata;
      end
    endcase
  end

  // Addressed lane(s) shifted down to bit 0 before extension
  assign w_sh = bus.mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_sh;
    unique case (1'b1)
      (r_size == 2'b00):
        w_ext = {{24{r_sign & w_sh[7]}}, w_sh[7:0]};
      (r_size == 2'b01):
        w_ext = {{16{r_sign & w_sh[15]}}, w_sh[15:0]};
      default:
        w_ext = w_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cpu_req) w_next = w_bad ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        if (r_cnt == LAST) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes decode from state so a reset removes them at once
  always_comb begin
    bus.mem_be    = 4'b0000;
    bus.mem_we    = 1'b0;
    bus.cpu_ready = 1'b0;
    bus.cpu_err   = 1'b0;
    unique case (r_state)
      S_ACCESS: begin
        bus.mem_be = r_be;
        bus.mem_we = r_we && (r_cnt == LAST);
      end
      S_RESP: begin
        bus.cpu_ready = 1'b1;
        bus.cpu_err   = r_err;
      end
      default: begin
        bus.mem_be = 4'b0000;
      end
    endcase
  end

  assign bus.mem_addr  = r_maddr;
  assign bus.mem_wdata = r_mwdata;
  assign bus.cpu_rdata = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_sign   <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= '0;
      r_off    <= '0;
      r_be     <= '0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_take) begin
        r_we   <= bus.cpu_we;
        r_sign <= bus.cpu_sign;
        r_size <= bus.cpu_size;
        r_off  <= bus.cpu_addr[1:0];
        r_err  <= w_bad;
        if (!w_bad) begin
          r_be     <= w_be;
          r_maddr  <= {bus.cpu_addr[31:2], 2'b00};
          r_mwdata <= w_wdata;
        end
      end
      if (r_state == S_ACCESS) r_cnt <= r_cnt + 4'd1;
      else                     r_cnt <= '0;
      if (w_last && !r_we) r_rdata <= w_ext;
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: three controllers (WAIT_CYCLES 2,1,4) on word memories,
// checked against a byte-addressed reference memory.
module tb_mio_bus_ctrl;

  logic clk;
  logic rst;

  logic        req   [3];
  logic        we    [3];
  logic [1:0]  size  [3];
  logic        sign  [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        err   [3];
  logic [31:0] maddr [3];
  logic [31:0] mwd   [3];
  logic        mwe   [3];
  logic [3:0]  mbe   [3];

  int checks = 0;
  int errors = 0;

  bit [7:0]  refm    [3][1024];
  bit [31:0] prev_rd [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    mio_bus_ctrl_if u_if ();
    logic [31:0] mem [256] = '{default: '0};

    assign u_if.cpu_req   = req[g];
    assign u_if.cpu_we    = we[g];
    assign u_if.cpu_size  = size[g];
    assign u_if.cpu_sign  = sign[g];
    assign u_if.cpu_addr  = addr[g];
    assign u_if.cpu_wdata = wdata[g];
    assign u_if.mem_rdata = mem[u_if.mem_addr[9:2]];
    assign rdata[g] = u_if.cpu_rdata;
    assign ready[g] = u_if.cpu_ready;
    assign err[g]   = u_if.cpu_err;
    assign maddr[g] = u_if.mem_addr;
    assign mwd[g]   = u_if.mem_wdata;
    assign mwe[g]   = u_if.mem_we;
    assign mbe[g]   = u_if.mem_be;

    always @(posedge clk) begin
      if (u_if.mem_we)
        for (int i = 0; i < 4; i++)
          if (u_if.mem_be[i])
            mem[u_if.mem_addr[9:2]][8*i +: 8] <= u_if.mem_wdata[8*i +: 8];
    end

    mio_bus_ctrl #(.WAIT_CYCLES(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
    );
  end

  function automatic int wc_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input int k);
    chk("rst_rdata", rdata[k], 32'h0);
    chk("rst_ready", 32'(ready[k]), 0);
    chk("rst_err", 32'(err[k]), 0);
    chk("rst_maddr", maddr[k], 32'h0);
    chk("rst_mwdata", mwd[k], 32'h0);
    chk("rst_mwe", 32'(mwe[k]), 0);
    chk("rst_mbe", 32'(mbe[k]), 0);
  endtask

  // Called at a negedge in an IDLE cycle; returns at the next IDLE negedge.
  task automatic access(input int k, input bit w, input bit [1:0] sz,
                        input bit sg, input bit [31:0] a,
                        input bit [31:0] d, input bit hold);
    int n, lat;
    bit bad;
    bit [3:0] ebe;
    bit [31:0] ewd, erd, v;
    n   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    bad = (sz == 3) || ((a % n) != 0);
    lat = bad ? 1 : wc_of(k) + 1;
    ebe = 4'(((1 << n) - 1) << (a % 4));
    ewd = (n == 1) ? d[7:0] * 32'h01010101 :
          (n == 2) ? d[15:0] * 32'h00010001 : d;
    erd = prev_rd[k];
    if (!bad && !w) begin
      v = 0;
      for (int i = 0; i < n; i++)
        v = v | (32'(refm[k][(a + i) % 1024]) << (8 * i));
      if (sg && n < 4 && v >= 32'(1 << (8 * n - 1)))
        v = v - 32'(1 << (8 * n));
      erd = v;
    end
    we[k] = w; size[k] = sz; sign[k] = sg;
    addr[k] = a; wdata[k] = d; req[k] = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) req[k] = 1'b0;
      if (c < lat) begin
        chk("acc_ready", 32'(ready[k]), 0);
        chk("acc_err", 32'(err[k]), 0);
        chk("acc_be", 32'(mbe[k]), 32'(ebe));
        chk("acc_we", 32'(mwe[k]), 32'(w && c == lat - 1));
        chk("acc_addr", maddr[k], a & 32'hFFFF_FFFC);
        if (w) chk("acc_wdata", mwd[k], ewd);
      end else begin
        chk("resp_ready", 32'(ready[k]), 1);
        chk("resp_err", 32'(err[k]), 32'(bad));
        chk("resp_be", 32'(mbe[k]), 0);
        chk("resp_we", 32'(mwe[k]), 0);
        chk("resp_rdata", rdata[k], erd);
      end
    end
    @(negedge clk);
    chk("idle_ready", 32'(ready[k]), 0);
    chk("idle_be", 32'(mbe[k]), 0);
    if (!bad && w)
      for (int i = 0; i < n; i++)
        refm[k][(a + i) % 1024] = d[8*i +: 8];
    prev_rd[k] = erd;
  endtask

  task automatic rand_access(input int k, input bit hold);
    bit [1:0] sz;
    bit [31:0] a;
    sz = 2'($urandom_range(0, 3));
    a  = $urandom_range(0, 1023);
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 1) a[0] = 1'b0;
      if (sz == 2) a[1:0] = 2'b00;
    end
    access(k, 1'($urandom), sz, 1'($urandom), a, $urandom, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; size[k] = 2'b10; sign[k] = 1'b0;
      addr[k] = '0; wdata[k] = '0; prev_rd[k] = '0;
    end
    req[0] = 1'b1; we[0] = 1'b1;
    addr[0] = 32'h104; wdata[0] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk_idle_outs(0);
    req[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_idle_outs(k);

    access(0, 1, 2'b10, 0, 32'h100, 32'h11223344, 0);
    access(0, 0, 2'b10, 0, 32'h100, 32'h0, 0);
    chk("word_load", rdata[0], 32'h11223344);
    access(0, 1, 2'b00, 0, 32'h103, 32'h000000A5, 0);
    access(0, 0, 2'b00, 1, 32'h103, 32'h0, 0);
    chk("sbyte_load", rdata[0], 32'hFFFFFFA5);
    access(0, 0, 2'b00, 0, 32'h103, 32'h0, 0);
    chk("ubyte_load", rdata[0], 32'h000000A5);
    access(0, 1, 2'b01, 0, 32'h102, 32'h00008001, 0);
    access(0, 0, 2'b01, 1, 32'h102, 32'h0, 0);
    chk("shalf_load", rdata[0], 32'hFFFF8001);
    access(0, 0, 2'b01, 0, 32'h102, 32'h0, 0);
    chk("uhalf_load", rdata[0], 32'h00008001);
    access(0, 0, 2'b01, 1, 32'h101, 32'h0, 0);
    access(0, 1, 2'b10, 0, 32'h102, 32'hCAFEF00D, 0);
    access(0, 0, 2'b11, 0, 32'h100, 32'h0, 0);
    access(0, 0, 2'b10, 0, 32'h100, 32'h0, 0);
    chk("word_after_err", rdata[0], 32'h80013344);

    for (int k = 0; k < 3; k++) begin
      repeat (30) rand_access(k, 0);
      repeat (12) rand_access(k, 1);
      req[k] = 1'b0;
      @(negedge clk);
      chk("held_drop", 32'(ready[k]), 0);
    end

    we[2] = 1'b1; size[2] = 2'b10; sign[2] = 1'b0;
    addr[2] = 32'h200; wdata[2] = 32'h5A5A0F0F; req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    chk("mid_be", 32'(mbe[2]), 32'hF);
    repeat (3) @(negedge clk);
    chk("mid_we", 32'(mwe[2]), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mwe[2]), 0);
    chk("mid_rst_be", 32'(mbe[2]), 0);
    chk("mid_rst_ready", 32'(ready[2]), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) prev_rd[k] = '0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_ready", 32'(ready[2]), 0);
    end
    for (int k = 0; k < 3; k++) chk_idle_outs(k);
    access(2, 0, 2'b10, 0, 32'h200, 32'h0, 0);
    repeat (10) rand_access(2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
